// File: rtl/custom_plic_irq_gateway.sv
// Conditions raw peripheral interrupt lines into PLIC-ready level interrupts:
// polarity fix-up, synchronisation, and edge-to-level conversion via saturating pending counters.
module custom_plic_irq_gateway #(
    parameter int                    SOURCE_NUM    = 32,
    parameter logic [SOURCE_NUM-1:0] EDGE_MASK     = '0,
    parameter logic [SOURCE_NUM-1:0] POLARITY_MASK = '0,
    parameter int                    SYNC_STAGES   = 2,
    parameter int                    CNT_WIDTH     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [SOURCE_NUM-1:0] intr_raw_i,
    input  logic [SOURCE_NUM-1:0] ack_i,
    input  logic                  ovf_clr_i,
    output logic [SOURCE_NUM-1:0] intr_src_o,
    output logic [SOURCE_NUM-1:0] ovf_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0][SOURCE_NUM-1:0] sync_q;
    logic [SOURCE_NUM-1:0]                  sync_s;

    // Polarity is applied before the first flop so every stage carries active-high data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], intr_raw_i ^ POLARITY_MASK};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Level sources never look at their ack bit; this keeps those bits visibly consumed.
    logic unused_inputs;
    assign unused_inputs = ^(ack_i & ~EDGE_MASK) ^ ovf_clr_i;

    for (genvar i = 0; i < SOURCE_NUM; i++) begin : g_src
        if (EDGE_MASK[i]) begin : g_edge
            logic                 prev_q;
            logic [CNT_WIDTH-1:0] cnt_q;
            logic [CNT_WIDTH-1:0] cnt_d;
            logic                 ovf_q;
            logic                 ovf_set;
            logic                 edge_ev;

            assign edge_ev = sync_s[i] & ~prev_q;

            // A coincident edge and ack cancel out, so that case falls through to hold.
            always_comb begin
                cnt_d   = cnt_q;
                ovf_set = 1'b0;
                case ({edge_ev, ack_i[i]})
                    2'b10: begin
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                        else                  ovf_set = 1'b1;
                    end
                    2'b01: begin
                        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
                    end
                    default: ;
                endcase
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    prev_q <= 1'b0;
                    cnt_q  <= '0;
                    ovf_q  <= 1'b0;
                end else begin
                    prev_q <= sync_s[i];
                    cnt_q  <= cnt_d;
                    // NOTE: set is OR-ed in after the clear mask, so a same-cycle overflow survives a clear.
                    ovf_q  <= ovf_set | (ovf_q & ~ovf_clr_i);
                end
            end

            assign intr_src_o[i] = (cnt_q != '0);
            assign ovf_o[i]      = ovf_q;
        end else begin : g_level
            assign intr_src_o[i] = sync_s[i];
            assign ovf_o[i]      = 1'b0;
        end
    end

endmodule
